vregfile_stream: RTL and testbench

VREGFILE_STREAM -- requirements
Module: vregfile_stream

---
 rtl/vregfile_pkg.sv | 14 +
 rtl/vregfile_fill_ctrl.sv | 93 +++++++++
 rtl/vregfile_stream.sv | 102 ++++++++++
 tb/tb_vregfile_stream.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vregfile_pkg.sv
// Shared defaults and fill-controller state encoding for the vector register file.
package vregfile_pkg;

    localparam int unsigned VRF_WIDTH  = 24;
    localparam int unsigned VRF_REGNUM = 16;
    localparam int unsigned VRF_VLEN   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/vregfile_fill_ctrl.sv
// Streaming-fill controller: latches the target register, counts accepted beats
// and yields to the direct write port whenever it is active.
module vregfile_fill_ctrl
    import vregfile_pkg::*;
#(
    parameter  int unsigned REGNUM = VRF_REGNUM,
    parameter  int unsigned VLEN   = VRF_VLEN,
    localparam int unsigned RW     = $clog2(REGNUM),
    localparam int unsigned IW     = $clog2(VLEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_start,
    input  logic [RW-1:0] fill_reg,
    input  logic          fill_valid,
    input  logic          we,
    output logic          fill_we,
    output logic [RW-1:0] fill_wreg,
    output logic [IW-1:0] fill_idx,
    output logic          fill_ready,
    output logic          fill_busy,
    output logic          fill_done
);

    fill_state_t   state_q, state_d;
    logic [RW-1:0] reg_q, reg_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    reg_d   = fill_reg;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + IW'(1);
                    if (cnt_q == IW'(VLEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Direct port has priority: fill stalls for any cycle with we asserted.
    always_comb begin
        fill_ready = 1'b0;
        fill_busy  = 1'b0;
        fill_done  = 1'b0;
        case (state_q)
            FILL: begin
                fill_ready = !we;
                fill_busy  = 1'b1;
            end
            DONE: begin
                fill_busy  = 1'b1;
                fill_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept    = fill_valid && fill_ready;
    assign fill_we   = accept;
    assign fill_wreg = reg_q;
    assign fill_idx  = cnt_q;

endmodule

// File: rtl/vregfile_stream.sv
// Vector register file with element/masked-vector direct writes, a streaming
// fill port and two registered write-first read ports.
module vregfile_stream
    import vregfile_pkg::*;
#(
    parameter  int unsigned WIDTH  = VRF_WIDTH,
    parameter  int unsigned REGNUM = VRF_REGNUM,
    parameter  int unsigned VLEN   = VRF_VLEN,
    localparam int unsigned RW     = $clog2(REGNUM),
    localparam int unsigned IW     = $clog2(VLEN),
    localparam int unsigned DW     = VLEN * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             wmode,
    input  logic [RW-1:0]    wreg,
    input  logic [IW-1:0]    windex,
    input  logic [WIDTH-1:0] wdata_elem,
    input  logic [DW-1:0]    wdata_vec,
    input  logic [VLEN-1:0]  wmask,
    input  logic [RW-1:0]    ra_reg,
    input  logic [RW-1:0]    rb_reg,
    output logic [DW-1:0]    ra_data,
    output logic [DW-1:0]    rb_data,
    input  logic             fill_start,
    input  logic [RW-1:0]    fill_reg,
    input  logic             fill_valid,
    input  logic [WIDTH-1:0] fill_data,
    output logic             fill_ready,
    output logic             fill_busy,
    output logic             fill_done
);

    logic [DW-1:0] regs_q [REGNUM];
    logic [DW-1:0] regs_d [REGNUM];
    logic [DW-1:0] ra_q, ra_d, rb_q, rb_d;
    logic          fill_we;
    logic [RW-1:0] fill_wreg;
    logic [IW-1:0] fill_idx;

    vregfile_fill_ctrl #(
        .REGNUM (REGNUM),
        .VLEN   (VLEN)
    ) u_fill_ctrl (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_reg   (fill_reg),
        .fill_valid (fill_valid),
        .we         (we),
        .fill_we    (fill_we),
        .fill_wreg  (fill_wreg),
        .fill_idx   (fill_idx),
        .fill_ready (fill_ready),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    // Fill and direct writes are mutually exclusive per cycle, so their order here is immaterial.
    always_comb begin
        regs_d = regs_q;
        if (fill_we) begin
            regs_d[fill_wreg][32'(fill_idx) * WIDTH +: WIDTH] = fill_data;
        end
        if (we && (32'(wreg) < REGNUM)) begin
            if (!wmode) begin
                if (32'(windex) < VLEN) begin
                    regs_d[wreg][32'(windex) * WIDTH +: WIDTH] = wdata_elem;
                end
            end else begin
                for (int unsigned i = 0; i < VLEN; i++) begin
                    if (wmask[i]) begin
                        regs_d[wreg][i * WIDTH +: WIDTH] = wdata_vec[i * WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Reading next-state contents gives write-first behaviour for both ports.
    always_comb begin
        ra_d = regs_d[ra_reg];
        rb_d = regs_d[rb_reg];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            ra_q   <= '0;
            rb_q   <= '0;
        end else begin
            regs_q <= regs_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
        end
    end

    assign ra_data = ra_q;
    assign rb_data = rb_q;

endmodule

// File: tb/tb_vregfile_stream.sv
// Directed bench for vregfile_stream: stimulus queues expectations tagged with
// the cycle they are due, a monitor compares them against the DUT outputs.
module tb_vregfile_stream;

    localparam int unsigned WIDTH  = 24;
    localparam int unsigned REGNUM = 16;
    localparam int unsigned VLEN   = 8;
    localparam int unsigned RW     = 4;
    localparam int unsigned IW     = 3;
    localparam int unsigned DW     = WIDTH * VLEN;

    typedef enum logic [2:0] {K_RA, K_RB, K_READY, K_BUSY, K_DONE} kind_e;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic             wmode;
    logic [RW-1:0]    wreg;
    logic [IW-1:0]    windex;
    logic [WIDTH-1:0] wdata_elem;
    logic [DW-1:0]    wdata_vec;
    logic [VLEN-1:0]  wmask;
    logic [RW-1:0]    ra_reg;
    logic [RW-1:0]    rb_reg;
    logic [DW-1:0]    ra_data;
    logic [DW-1:0]    rb_data;
    logic             fill_start;
    logic [RW-1:0]    fill_reg;
    logic             fill_valid;
    logic [WIDTH-1:0] fill_data;
    logic             fill_ready;
    logic             fill_busy;
    logic             fill_done;

    int unsigned      cyc = 0;
    int unsigned      total = 0;
    int unsigned      bad = 0;
    logic             finish_req = 1'b0;
    logic [DW-1:0]    act;

    string            q_name[$];
    kind_e            q_kind[$];
    logic [DW-1:0]    q_exp[$];
    int unsigned      q_at[$];

    vregfile_stream #(
        .WIDTH  (WIDTH),
        .REGNUM (REGNUM),
        .VLEN   (VLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wmode      (wmode),
        .wreg       (wreg),
        .windex     (windex),
        .wdata_elem (wdata_elem),
        .wdata_vec  (wdata_vec),
        .wmask      (wmask),
        .ra_reg     (ra_reg),
        .rb_reg     (rb_reg),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .fill_start (fill_start),
        .fill_reg   (fill_reg),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .fill_ready (fill_ready),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] lane(int unsigned i, logic [WIDTH-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        r[i * WIDTH +: WIDTH] = v;
        return r;
    endfunction

    // dly = 0: due at this cycle's negedge; dly = 1: due after the next posedge.
    function automatic void expect_at(string n, kind_e k, logic [DW-1:0] e, int unsigned dly);
        q_name.push_back(n);
        q_kind.push_back(k);
        q_exp.push_back(e);
        q_at.push_back(cyc + dly);
    endfunction

    function automatic void expect_status(string n, logic rdy, logic bsy, logic dne);
        expect_at({n, "_ready"}, K_READY, DW'(rdy), 0);
        expect_at({n, "_busy"},  K_BUSY,  DW'(bsy), 0);
        expect_at({n, "_done"},  K_DONE,  DW'(dne), 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        for (int i = int'(q_at.size()) - 1; i >= 0; i--) begin
            if (q_at[i] <= cyc) begin
                case (q_kind[i])
                    K_RA:    act = ra_data;
                    K_RB:    act = rb_data;
                    K_READY: act = DW'(fill_ready);
                    K_BUSY:  act = DW'(fill_busy);
                    default: act = DW'(fill_done);
                endcase
                total = total + 1;
                if (q_at[i] != cyc || act !== q_exp[i]) begin
                    bad = bad + 1;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", q_name[i], act, q_exp[i], cyc);
                end
                q_name.delete(i);
                q_kind.delete(i);
                q_exp.delete(i);
                q_at.delete(i);
            end
        end
        if (finish_req) begin
            for (int i = 0; i < int'(q_name.size()); i++) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL %s: never checked, expected %h", q_name[i], q_exp[i]);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] e5, e7, e8, e10;

        rst = 1'b1; we = 1'b0; wmode = 1'b0; wreg = '0; windex = '0;
        wdata_elem = '0; wdata_vec = '0; wmask = '0; ra_reg = '0; rb_reg = '0;
        fill_start = 1'b0; fill_reg = '0; fill_valid = 1'b0; fill_data = '0;

        step();
        step();
        expect_at("rst_ra", K_RA, '0, 0);
        expect_at("rst_rb", K_RB, '0, 0);
        expect_status("rst", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // element write reg3 idx2, read back with same-cycle bypass then plain read
        we = 1'b1; wmode = 1'b0; wreg = 4'd3; windex = 3'd2; wdata_elem = 24'hABCDE;
        ra_reg = 4'd3; rb_reg = 4'd4;
        expect_at("elem_bypass_ra", K_RA, lane(2, 24'hABCDE), 1);
        expect_at("elem_other_rb", K_RB, '0, 1);
        step();
        we = 1'b0; rb_reg = 4'd3;
        expect_at("elem_read_ra", K_RA, lane(2, 24'hABCDE), 1);
        expect_at("elem_read_rb", K_RB, lane(2, 24'hABCDE), 1);
        step();

        // same-cycle write reg2 idx0 with ra_reg=2
        we = 1'b1; wreg = 4'd2; windex = 3'd0; wdata_elem = 24'h000123; ra_reg = 4'd2;
        expect_at("bypass_reg2", K_RA, lane(0, 24'h000123), 1);
        step();

        // masked vector write reg5
        we = 1'b1; wmode = 1'b1; wreg = 4'd5; wmask = 8'b1010_0101;
        for (int unsigned i = 0; i < VLEN; i++) wdata_vec[i * WIDTH +: WIDTH] = 24'(i + 1);
        ra_reg = 4'd5;
        e5 = lane(0, 24'd1) | lane(2, 24'd3) | lane(5, 24'd6) | lane(7, 24'd8);
        expect_at("vec_mask_a5", K_RA, e5, 1);
        step();
        wmask = 8'b0000_0010; wdata_vec = '1; rb_reg = 4'd2;
        e5 = e5 | lane(1, 24'hFFFFFF);
        expect_at("vec_mask_02", K_RA, e5, 1);
        expect_at("reg2_kept", K_RB, lane(0, 24'h000123), 1);
        step();
        we = 1'b0; wmode = 1'b0; wmask = '0;

        // fill reg7 with 0x10..0x17, fill_start in FILL must be ignored
        fill_start = 1'b1; fill_reg = 4'd7;
        expect_status("fill7_idle", 1'b0, 1'b0, 1'b0);
        step();
        e7 = '0;
        for (int unsigned b = 0; b < VLEN; b++) begin
            fill_valid = 1'b1;
            fill_data = 24'(32'h10 + b);
            e7 = e7 | lane(b, 24'(32'h10 + b));
            fill_start = (b == 2);
            fill_reg = (b == 2) ? 4'd9 : 4'd7;
            expect_status("fill7_beat", 1'b1, 1'b1, 1'b0);
            if (b == VLEN - 1) begin
                rb_reg = 4'd7;
                expect_at("fill7_bypass_rb", K_RB, e7, 1);
            end
            step();
        end
        fill_valid = 1'b0; fill_start = 1'b0;
        expect_status("fill7_donecyc", 1'b0, 1'b1, 1'b1);
        step();
        expect_status("fill7_after", 1'b0, 1'b0, 1'b0);
        ra_reg = 4'd7; rb_reg = 4'd9;
        expect_at("fill7_read", K_RA, e7, 1);
        expect_at("fill_start_ignored_reg9", K_RB, '0, 1);
        step();

        // fill reg8 with a direct write stalling beat 3 (targets lane 7 of reg8)
        fill_start = 1'b1; fill_reg = 4'd8;
        step();
        fill_start = 1'b0;
        begin
            int unsigned b;
            b = 0;
            for (int unsigned c = 0; c < VLEN + 1; c++) begin
                fill_valid = 1'b1;
                fill_data = 24'(32'h20 + b);
                if (c == 3) begin
                    we = 1'b1; wmode = 1'b0; wreg = 4'd8; windex = 3'd7; wdata_elem = 24'h000999;
                    expect_status("stall_beat3", 1'b0, 1'b1, 1'b0);
                end else begin
                    we = 1'b0;
                    expect_status("fill8_beat", 1'b1, 1'b1, 1'b0);
                end
                step();
                if (c != 3) b = b + 1;
            end
        end
        we = 1'b0; fill_valid = 1'b0;
        expect_status("fill8_donecyc", 1'b0, 1'b1, 1'b1);
        e8 = '0;
        for (int unsigned i = 0; i < VLEN; i++) e8 = e8 | lane(i, 24'(32'h20 + i));
        step();
        ra_reg = 4'd8;
        expect_at("fill8_read", K_RA, e8, 1);
        step();

        // reset after beat 4 of a fill of reg10
        fill_start = 1'b1; fill_reg = 4'd10;
        step();
        fill_start = 1'b0;
        for (int unsigned b = 0; b < 4; b++) begin
            fill_valid = 1'b1;
            fill_data = 24'(32'h30 + b);
            step();
        end
        ra_reg = 4'd3; rb_reg = 4'd7;
        rst = 1'b1; fill_valid = 1'b0;
        expect_at("midrst_ra", K_RA, '0, 0);
        expect_at("midrst_rb", K_RB, '0, 0);
        expect_status("midrst", 1'b0, 1'b0, 1'b0);
        step();
        expect_status("midrst_hold", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        ra_reg = 4'd10; rb_reg = 4'd3;
        fill_start = 1'b1; fill_reg = 4'd10;
        expect_at("postrst_reg10", K_RA, '0, 1);
        expect_at("postrst_reg3", K_RB, '0, 1);
        expect_status("postrst_idle", 1'b0, 1'b0, 1'b0);
        step();
        fill_start = 1'b0;
        e10 = '0;
        for (int unsigned b = 0; b < VLEN; b++) begin
            fill_valid = 1'b1;
            fill_data = 24'(32'h40 + b);
            e10 = e10 | lane(b, 24'(32'h40 + b));
            expect_status("refill_beat", 1'b1, 1'b1, 1'b0);
            step();
        end
        fill_valid = 1'b0;
        expect_status("refill_donecyc", 1'b0, 1'b1, 1'b1);
        step();
        ra_reg = 4'd10; rb_reg = 4'd7;
        expect_at("refill_read", K_RA, e10, 1);
        expect_at("postrst_reg7", K_RB, '0, 1);
        step();
        step();
        finish_req = 1'b1;
    end

endmodule
